// File: rtl/key_pkg.sv
// Shared types and default constants for the key press detector.
// The auto-repeat constants only matter when KEY_REPEAT_EN is defined.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } key_state_t;

    localparam int unsigned KEY_DEBOUNCE_DEF      = 500000;
    localparam int unsigned KEY_REPEAT_DELAY_DEF  = 25000000;
    localparam int unsigned KEY_REPEAT_PERIOD_DEF = 5000000;

    function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_timer.sv
// Clear/increment counter with a terminal compare against a supplied limit.
// Clear wins over increment; the owner guarantees it never counts past the limit.
module key_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_term = (r_count == i_limit);

endmodule

// File: rtl/key_press_detect.sv
// Debounced key press detector: one-cycle Press per accepted press, Held while down.
// Define KEY_REPEAT_EN to add auto-repeat Press pulses while the key stays held.
module key_press_detect
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
    parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Key,
    output logic Press,
    output logic Held
);

    localparam int unsigned    DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LIMIT = DEB_W'(DEBOUNCE_CYCLES - 1);

    key_state_t r_state;
    logic       r_press;
    logic       r_held;

    logic w_deb_term;
    logic w_deb_inc;
    logic w_deb_clr;
    logic w_rep_fire;

    // Debounce counter only advances while the key agrees with the pending transition.
    assign w_deb_inc = ((r_state == StPressWait)   &&  Key && !w_deb_term) ||
                       ((r_state == StReleaseWait) && !Key && !w_deb_term);
    assign w_deb_clr = !w_deb_inc;

    key_timer #(
        .WIDTH (DEB_W)
    ) u_deb_timer (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_clr   (w_deb_clr),
        .i_inc   (w_deb_inc),
        .i_limit (DEB_LIMIT),
        .o_term  (w_deb_term)
    );

`ifdef KEY_REPEAT_EN
    localparam int unsigned      REP_W      = $clog2(key_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD - 1);

    logic             r_rep_phase;
    logic             w_rep_term;
    logic             w_rep_inc;
    logic             w_rep_clr;
    logic [REP_W-1:0] w_rep_limit;

    // Phase 0 waits out the initial delay, phase 1 paces later repeats.
    assign w_rep_limit = r_rep_phase ? REP_PERIOD : REP_DELAY;
    assign w_rep_fire  = (r_state == StHeld) && Key &&  w_rep_term;
    assign w_rep_inc   = (r_state == StHeld) && Key && !w_rep_term;
    assign w_rep_clr   = !w_rep_inc;

    key_timer #(
        .WIDTH (REP_W)
    ) u_rep_timer (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_clr   (w_rep_clr),
        .i_inc   (w_rep_inc),
        .i_limit (w_rep_limit),
        .o_term  (w_rep_term)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rep_phase <= 1'b0;
        end else if ((r_state != StHeld) || !Key) begin
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_phase <= 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= StIdle;
            r_press <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (Key) begin
                        r_state <= StPressWait;
                    end
                end
                StPressWait: begin
                    if (!Key) begin
                        r_state <= StIdle;
                    end else if (w_deb_term) begin
                        r_state <= StHeld;
                        r_press <= 1'b1;
                        r_held  <= 1'b1;
                    end
                end
                StHeld: begin
                    if (!Key) begin
                        r_state <= StReleaseWait;
                    end else begin
                        r_press <= w_rep_fire;
                    end
                end
                StReleaseWait: begin
                    if (Key) begin
                        r_state <= StHeld;
                    end else if (w_deb_term) begin
                        r_state <= StIdle;
                        r_held  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign Press = r_press;
    assign Held  = r_held;

endmodule

// File: doc/key_press_detect.md
KEY_PRESS_DETECT -- requirements
Module: key_press_detect

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable samples needed to accept a press or release (10 ms at 50 MHz); legal range is 1 or more.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of HELD cycles before the first auto-repeat pulse; used only under KEY_REPEAT_EN.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the number of cycles between later auto-repeat pulses; used only under KEY_REPEAT_EN.
REQ-004 Port Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port Key, input, 1 bit: key level already synchronized to Clock, with 1 = pressed.
REQ-007 Port Press, output, 1 bit: registered, one-cycle pulse per accepted press (and per repeat when enabled).
REQ-008 Port Held, output, 1 bit: registered, high while the debounced key is considered down.

Function
REQ-009 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-010 In IDLE, when Key=1 is sampled, the FSM goes to PRESS_WAIT and clears cnt to 0; when Key=0, it stays in IDLE.
REQ-011 In PRESS_WAIT:
- Key=0: go to IDLE (bounce rejected); no Press.
- Key=1 with cnt<DEBOUNCE_CYCLES-1: cnt increments.
- Key=1 with cnt==DEBOUNCE_CYCLES-1: go to HELD.
REQ-012 Press latency: with the first Key=1 sampled at edge 0, Key must stay 1 through edge DEBOUNCE_CYCLES; Press is high for the single cycle after that edge.
REQ-013 Press is asserted on the same edge that enters HELD from PRESS_WAIT, and for exactly one cycle.
REQ-014 In HELD, when Key=0 is sampled, the FSM goes to RELEASE_WAIT and clears cnt to 0.
REQ-015 In RELEASE_WAIT:
- Key=1: return to HELD with no new Press (release bounce).
- Key=0 with cnt==DEBOUNCE_CYCLES-1: go to IDLE.
- Otherwise: cnt increments.
REQ-016 Held is 1 exactly when the state is HELD or RELEASE_WAIT, registered together with the state.
REQ-017 The counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps, because each terminal compare forces a state change.
REQ-018 Any Key pattern shorter than DEBOUNCE_CYCLES+1 consecutive samples produces no Press and no Held.

Reset
REQ-019 When Reset=1 is sampled: state becomes IDLE, all counters become 0, Press=0, Held=0.
REQ-020 Reset has priority over every transition, including an edge that would otherwise assert Press.
REQ-021 A key held through a reset is debounced again from IDLE after Reset deasserts, and produces a Press once it qualifies.

Configuration
REQ-022 With macro KEY_REPEAT_EN defined:
- A repeat counter clears to 0 in every state other than HELD.
- The repeat counter increments each cycle the FSM is in HELD.
- Press pulses once when REPEAT_DELAY HELD cycles have elapsed, then once every REPEAT_PERIOD cycles while the FSM stays in HELD.
REQ-023 Under KEY_REPEAT_EN, entering RELEASE_WAIT stops repeats; returning to HELD from RELEASE_WAIT restarts the REPEAT_DELAY phase.
REQ-024 Without KEY_REPEAT_EN, no repeat logic is synthesized and Press occurs exactly once per accepted press.

Structure
REQ-025 Shared package key_pkg holds:
- the state enum typedef key_state_t;
- default constants KEY_DEBOUNCE_DEF, KEY_REPEAT_DELAY_DEF and KEY_REPEAT_PERIOD_DEF.
REQ-026 Sub-module key_timer is a clear/increment/terminal-compare counter, instantiated once for debounce and, under KEY_REPEAT_EN, once for repeat.
REQ-027 The block contains no synchronizer; Key is driven by the existing upstream two-flop synchronizer.

Verification (benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-028 Clean press: Key=1 from edge 0 for 20 cycles -> Press high only after edge 4; Held high from edge 4 until 5 cycles after Key falls.
REQ-029 Press bounce: Key pattern 1,1,0,1,1,1,0 -> Press never asserts; Held stays 0.
REQ-030 Release bounce: while in HELD, Key 0,0,1 then held 1 -> Held stays 1 and no second Press.
REQ-031 Reset mid-operation: Reset=1 at edge 3 of PRESS_WAIT, Key held 1 -> Press=0, Held=0; then a fresh Press 4 edges after the first Key=1 sampled after reset.
REQ-032 KEY_REPEAT_EN with Key held 20 cycles -> Press at HELD cycles 0, 8, 11, 14, 17; no Press after Key falls.
REQ-033 Reset and qualifying edge together: Reset=1 on the edge that would enter HELD -> Press stays 0 and state is IDLE.
